// File: rtl/md_sched.sv
// Multiply/divide scheduler for the E stage: owns HI/LO, sequences multi-cycle
// mult/div with a down-counter and requests a freeze while a D-stage HI/LO user must wait.
//
//   state | meaning
//   IDLE  | no operation in flight; accepts mult/div/mthi/mtlo
//   BUSY  | counting down; pending result lands on HI/LO at terminal count
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall_md,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_wr;

    logic               is_mul;
    logic               is_div;
    logic               is_md_op;
    logic               div_by_zero;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               rs_neg;
    logic               rt_neg;
    logic [31:0]        rs_mag;
    logic [31:0]        rt_mag;
    logic [31:0]        divisor;
    logic [31:0]        quo_mag;
    logic [31:0]        rem_mag;
    logic [31:0]        quo;
    logic [31:0]        rem;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;

    assign is_mul      = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div      = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_md_op    = is_mul || is_div;
    assign div_by_zero = is_div && (rt_val == 32'd0);

    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign rs_neg  = (op == OP_DIV) && rs_val[31];
    assign rt_neg  = (op == OP_DIV) && rt_val[31];
    assign rs_mag  = rs_neg ? (32'd0 - rs_val) : rs_val;
    assign rt_mag  = rt_neg ? (32'd0 - rt_val) : rt_val;
    assign divisor = (rt_val == 32'd0) ? 32'd1 : rt_mag;
    assign quo_mag = rs_mag / divisor;
    assign rem_mag = rs_mag % divisor;
    assign quo     = (rs_neg ^ rt_neg) ? (32'd0 - quo_mag) : quo_mag;
    assign rem     = rs_neg ? (32'd0 - rem_mag) : rem_mag;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        if (op == OP_MULT) begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
        end else if (op == OP_MULTU) begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
        end else if (is_div) begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && is_md_op) begin
                    pend_hi <= res_hi;
                    pend_lo <= res_lo;
                    pend_wr <= !div_by_zero;
                    cnt     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state   <= BUSY;
                end else if (start && (op == OP_MTHI)) begin
                    hi <= rs_val;
                end else if (start && (op == OP_MTLO)) begin
                    lo <= rs_val;
                end
            end else begin
                // Terminal count: commit (unless divide by zero) and free up for back-to-back issue.
                if (cnt == CNT_W'(1)) begin
                    if (pend_wr) begin
                        hi <= pend_hi;
                        lo <= pend_lo;
                    end
                    done  <= 1'b1;
                    cnt   <= '0;
                    state <= IDLE;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

    assign busy     = (state == BUSY);
    assign stall_md = d_is_md && (busy || (start && is_md_op));

endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide scheduler for the E stage of the five-stage pipeline. It accepts mult/multu/div/divu/mthi/mtlo operations and holds the HI/LO registers. It sequences each multi-cycle operation with a busy counter. It raises a stall request to the hazard/freeze logic while a D-stage instruction that touches HI/LO must wait.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start  input  1  E-stage instruction is an MD operation this cycle
- op  input  3  001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; 000/111 = no-op
- rs_val  input  32  forwarded GPR[rs] (dividend / multiplicand / mthi-mtlo source)
- rt_val  input  32  forwarded GPR[rt] (divisor / multiplier)
- d_is_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  output  1  operation in progress
- stall_md  output  1  stall request to the freeze logic (combinational)
- done  output  1  one-cycle pulse on the cycle new HI/LO become visible
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- States: IDLE, BUSY. Reset → IDLE, counter=0, hi=0, lo=0, busy=0, done=0, pending result regs=0.
- IDLE, start=1, op∈{mult,multu,div,divu}:
  - latch the 64-bit result into pending regs;
  - counter ← MULT_CYCLES or DIV_CYCLES;
  - go to BUSY.
- IDLE, start=1, op=mthi: hi ← rs_val next edge; op=mtlo: lo ← rs_val; no BUSY, no done.
- BUSY: counter decrements each edge. At the edge where counter==1, hi/lo ← pending, state → IDLE, done=1 for the following cycle.
- start while BUSY (any op): ignored. Counter, pending regs and HI/LO are unaffected. The freeze logic prevents this case; the block does not rely on it.
- start with op 000/111: ignored.
- Arithmetic:
  - mult: signed 32×32 → 64; hi=[63:32], lo=[31:0].
  - multu: unsigned 32×32 → 64.
  - div/divu: lo=quotient, hi=remainder. Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divisor 0 (div or divu): full busy period runs, done pulses, hi/lo retain their previous values.
- stall_md = d_is_md & (busy | (start & op∈{mult,multu,div,divu})). mfhi/mflo in D never reads stale HI/LO.
- Reset mid-operation: the pending result is discarded, and all outputs return to reset values on the next edge.

## Timing
- Start sampled at edge t. busy=1 in cycles t+1 … t+N (N = MULT_CYCLES/DIV_CYCLES). New hi/lo and done=1 appear in cycle t+N+1, and busy=0 in that cycle.
- A new mult/div may start in cycle t+N+1 (back-to-back, no idle gap).
- stall_md is combinational. It is high in cycle t (start) and in t+1 … t+N whenever d_is_md=1, and low in t+N+1.
- mthi/mtlo value is visible on hi/lo in the cycle after start.
- Reset dominates start in the same cycle.

## Test plan
- mult rs=0xFFFFFFFD (−3), rt=7 → busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB; done one cycle.
- multu rs=0xFFFFFFFF, rt=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles. Immediately issue div rs=0xFFFFFFF9 (−7), rt=2 → busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- d_is_md=1 held from the start cycle through completion → stall_md high for 11 consecutive cycles (start + 10 busy), low on the done cycle. With d_is_md=0 → stall_md stays 0.
- mthi rs=0x12345678 then divu rt=0 → hi=0x12345678 next cycle. After 10 busy cycles, done pulses and hi/lo remain 0x12345678/prior lo.
- div started, reset asserted in busy cycle 4 → next cycle busy=0, hi=lo=0, done never pulses. A following mult 3×4 gives lo=12, hi=0.
- start=1 with op=mult in busy cycle 2 of a div → ignored. Div result is correct, and busy ends at the original cycle.
